down_count_bcd_311: RTL and testbench

- Consumes the 8-bit count produced by the down counter and converts it to three BCD digits (hundreds, tens, ones) for a display driver further downstream.
- Uses a sequential shift-and-add-3 (double-dabble) engine, one bit per clock, with a start/busy/done handshake.
- An optional auto mode starts a conversion whenever the incoming count differs from the last converted value. The display then tracks a free-running counter without external control.

---
 rtl/down_count_bcd_311.sv | 103 ++++++++++
 tb/tb_down_count_bcd_311.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_count_bcd_311.sv
// Binary-to-BCD converter for the down counter display path: sequential
// double-dabble, one bit per clock, with start/busy/done handshake and optional auto-start.
module down_count_bcd_311 #(
  parameter int AUTO  = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_311,
  input  logic             reset_311,
  input  logic [WIDTH-1:0] count_in_311,
  input  logic             start_311,
  output logic             busy_311,
  output logic             done_311,
  output logic [3:0]       bcd_hund_311,
  output logic [3:0]       bcd_tens_311,
  output logic [3:0]       bcd_ones_311
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic       AUTO_EN  = (AUTO != 32'sd0);

  logic [0:0]       state_r;
  logic [19:0]      shift_r;
  logic [3:0]       bit_cnt_r;
  logic [WIDTH-1:0] last_r;
  logic             busy_r;
  logic             done_r;
  logic [3:0]       hund_r;
  logic [3:0]       tens_r;
  logic [3:0]       ones_r;

  logic             start_s;
  logic [19:0]      next_shift_s;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble iteration: correct each digit nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] adj;
    adj = {add3(v[19:16]), add3(v[15:12]), add3(v[11:8]), v[7:0]};
    return {adj[18:0], 1'b0};
  endfunction

  // Start request: explicit start, or (auto mode) the input moved away from the last captured value.
  always_comb begin
    start_s      = start_311 | (AUTO_EN & (count_in_311 != last_r));
    next_shift_s = dabble_step(shift_r);
  end

  // Conversion FSM, shift engine and registered result digits.
  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      state_r   <= ST_IDLE;
      shift_r   <= 20'd0;
      bit_cnt_r <= 4'd0;
      last_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hund_r    <= 4'd0;
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            shift_r   <= {12'd0, count_in_311};
            last_r    <= count_in_311;
            bit_cnt_r <= 4'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_r   <= next_shift_s;
          bit_cnt_r <= bit_cnt_r + 4'd1;
          // Eighth shift: digits are final, publish them in the same edge.
          if (bit_cnt_r == 4'd7) begin
            hund_r  <= next_shift_s[19:16];
            tens_r  <= next_shift_s[15:12];
            ones_r  <= next_shift_s[11:8];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_311     = busy_r;
  assign done_311     = done_r;
  assign bcd_hund_311 = hund_r;
  assign bcd_tens_311 = tens_r;
  assign bcd_ones_311 = ones_r;

endmodule

// File: tb/tb_down_count_bcd_311.sv
// Scoreboard bench for down_count_bcd_311: one manual-start instance and one auto-mode
// instance; expected digits and completion cycles are queued at stimulus time.
module tb_down_count_bcd_311;

  typedef struct {
    logic [11:0] dig;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Manual-start instance
  logic       reset0 = 1'b1;
  logic       start0 = 1'b0;
  logic [7:0] cnt0   = 8'd0;
  logic       busy0, done0;
  logic [3:0] h0, t0, o0;

  // Auto-mode instance fed by a falling-edge down counter or a manual value
  logic       reset1  = 1'b1;
  logic       start1  = 1'b0;
  logic       use_ctr = 1'b0;
  logic       ctr_run = 1'b0;
  logic [7:0] ctr     = 8'd255;
  logic [7:0] man1    = 8'd0;
  logic [7:0] cnt1;
  logic       busy1, done1;
  logic [3:0] h1, t1, o1;

  assign cnt1 = use_ctr ? ctr : man1;

  always @(negedge clk) if (ctr_run) ctr <= ctr - 8'd1;

  down_count_bcd_311 #(.AUTO(0), .WIDTH(8)) dut0 (
    .clk_311(clk), .reset_311(reset0), .count_in_311(cnt0), .start_311(start0),
    .busy_311(busy0), .done_311(done0),
    .bcd_hund_311(h0), .bcd_tens_311(t0), .bcd_ones_311(o0)
  );

  down_count_bcd_311 #(.AUTO(1), .WIDTH(8)) dut1 (
    .clk_311(clk), .reset_311(reset1), .count_in_311(cnt1), .start_311(start1),
    .busy_311(busy1), .done_311(done1),
    .bcd_hund_311(h1), .bcd_tens_311(t1), .bcd_ones_311(o1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] bcd3(input int h, input int t, input int o);
    logic [3:0] hh, tt, oo;
    hh = h[3:0];
    tt = t[3:0];
    oo = o[3:0];
    return {hh, tt, oo};
  endfunction

  // Queue a result due nine edges from now (accept edge + eight shifts).
  task automatic push0(input int h, input int t, input int o, input int lat);
    exp_t e;
    e.dig = bcd3(h, t, o);
    e.due = cyc + lat;
    q0.push_back(e);
  endtask

  task automatic push1(input int h, input int t, input int o, input int lat);
    exp_t e;
    e.dig = bcd3(h, t, o);
    e.due = cyc + lat;
    q1.push_back(e);
  endtask

  // Start a manual conversion and step to the done cycle, checking busy along the way.
  task automatic convert0(input logic [7:0] v, input int h, input int t, input int o);
    cnt0   = v;
    start0 = 1'b1;
    push0(h, t, o, 9);
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("busy0 during conversion", int'(busy0), 1);
      tick();
    end
  endtask

  // Monitor for the manual instance
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut0 unexpected done: digits %0d%0d%0d at cycle %0d", h0, t0, o0, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 digits", int'({h0, t0, o0}), int'(e.dig));
        chk("dut0 done cycle", cyc, e.due);
        chk("dut0 busy with done", int'(busy0), 0);
      end
    end
  end

  // Monitor for the auto instance
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut1 unexpected done: digits %0d%0d%0d at cycle %0d", h1, t1, o1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 digits", int'({h1, t1, o1}), int'(e.dig));
        chk("dut1 done cycle", cyc, e.due);
        chk("dut1 busy with done", int'(busy1), 0);
      end
    end
  end

  initial begin
    // Test 1: reset state, then 255 -> 2/5/5 and hold
    tick();
    tick();
    reset0 = 1'b0;
    chk("reset busy0", int'(busy0), 0);
    chk("reset done0", int'(done0), 0);
    chk("reset digits0", int'({h0, t0, o0}), 0);
    convert0(8'd255, 2, 5, 5);
    chk("busy0 in done cycle", int'(busy0), 0);
    repeat (4) tick();
    chk("hold digits 255", int'({h0, t0, o0}), int'(bcd3(2, 5, 5)));
    chk("hold done0 low", int'(done0), 0);

    // Test 2: back-to-back, each start in the done cycle
    convert0(8'd199, 1, 9, 9);
    convert0(8'd0,   0, 0, 0);
    convert0(8'd100, 1, 0, 0);
    tick();

    // Test 3: start re-asserted while busy is ignored
    cnt0   = 8'd128;
    start0 = 1'b1;
    push0(1, 2, 8, 9);
    tick();
    start0 = 1'b0;
    repeat (2) tick();
    cnt0   = 8'd37;
    start0 = 1'b1;
    repeat (3) tick();
    start0 = 1'b0;
    repeat (3) tick();
    repeat (12) tick();
    chk("no second conversion", int'(busy0), 0);
    chk("digits 128 held", int'({h0, t0, o0}), int'(bcd3(1, 2, 8)));

    // Test 4: reset on the 4th busy cycle aborts
    cnt0   = 8'd255;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("busy0 before abort", int'(busy0), 1);
    repeat (3) tick();
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    chk("abort busy0", int'(busy0), 0);
    chk("abort done0", int'(done0), 0);
    chk("abort digits0", int'({h0, t0, o0}), 0);
    repeat (12) tick();
    chk("abort idle busy0", int'(busy0), 0);
    chk("abort digits stay 0", int'({h0, t0, o0}), 0);

    // Test 5: auto mode tracking a free-running down counter
    use_ctr = 1'b1;
    reset1  = 1'b1;
    tick();
    reset1 = 1'b0;
    chk("reset busy1", int'(busy1), 0);
    chk("reset digits1", int'({h1, t1, o1}), 0);
    push1(2, 5, 5, 9);
    push1(2, 4, 6, 18);
    push1(2, 3, 7, 27);
    push1(2, 2, 8, 36);
    tick();
    ctr_run = 1'b1;
    chk("auto busy1 after first edge", int'(busy1), 1);
    repeat (35) tick();
    ctr_run = 1'b0;
    reset1  = 1'b1;
    tick();
    reset1 = 1'b0;

    // Test 6: auto mode with input 0 never starts; then 9 -> 0/0/9
    use_ctr = 1'b0;
    man1    = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("auto zero busy1", int'(busy1), 0);
    end
    chk("auto zero digits1", int'({h1, t1, o1}), 0);
    man1 = 8'd9;
    push1(0, 0, 9, 9);
    tick();
    chk("auto 9 busy1", int'(busy1), 1);
    repeat (14) tick();
    chk("auto 9 idle", int'(busy1), 0);
    chk("auto 9 digits held", int'({h1, t1, o1}), int'(bcd3(0, 0, 9)));

    repeat (2) tick();
    chk("dut0 queue drained", q0.size(), 0);
    chk("dut1 queue drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
